// File: rtl/kernel_b_stream_ctrl.sv
// kernel_b_stream_ctrl: job sequencing and flow gating around a streaming kernel.
// Limits items in flight inside the kernel and counts items in and out.
module kernel_b_stream_ctrl #(
    parameter int CNTW    = 32,
    parameter int MAXINFL = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            abort,
    input  logic [CNTW-1:0] nitems,
    output logic            busy,
    output logic            done,
    output logic [CNTW-1:0] in_cnt,
    output logic [CNTW-1:0] out_cnt,
    input  logic            src_valid,
    output logic            src_ready,
    output logic            k_ivalid,
    input  logic            k_iready,
    input  logic            k_ovalid,
    output logic            k_oready,
    output logic            snk_valid,
    input  logic            snk_ready
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;
    localparam logic [7:0] MAX_INFL = 8'(MAXINFL);

    logic [1:0]      state;
    logic [CNTW-1:0] n_lat;
    logic [7:0]      inflight;
    logic            gate_in, gate_out, in_acc, out_acc, in_last, out_last;

    always_comb begin
        gate_in   = (state == RUN) && (in_cnt < n_lat) && (inflight < MAX_INFL);
        gate_out  = (state == RUN) || (state == DRAIN);
        k_ivalid  = src_valid & gate_in;
        src_ready = k_iready & gate_in;
        snk_valid = k_ovalid & gate_out;
        k_oready  = snk_ready & gate_out;
        in_acc    = k_ivalid & k_iready;
        out_acc   = snk_valid & snk_ready;
        in_last   = in_acc && (in_cnt + CNTW'(1) == n_lat);
        out_last  = out_acc && (out_cnt + CNTW'(1) == n_lat);
        busy      = gate_out;
        done      = (state == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            n_lat    <= '0;
            in_cnt   <= '0;
            out_cnt  <= '0;
            inflight <= '0;
        end else if (gate_out && abort) begin
            state <= IDLE;
        end else begin
            if (in_acc) in_cnt <= in_cnt + CNTW'(1);
            if (out_acc) out_cnt <= out_cnt + CNTW'(1);
            if (in_acc != out_acc) inflight <= in_acc ? inflight + 8'd1 : inflight - 8'd1;
            case (state)
                IDLE: if (start) begin
                    n_lat    <= nitems;
                    in_cnt   <= '0;
                    out_cnt  <= '0;
                    inflight <= '0;
                    state    <= (nitems == '0) ? DONE : RUN;
                end
                // a zero-latency kernel can finish the last item in the same cycle it enters
                RUN:     state <= out_last ? DONE : in_last ? DRAIN : RUN;
                DRAIN:   state <= out_last ? DONE : DRAIN;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_kernel_b_stream_ctrl.sv
// tb_kernel_b_stream_ctrl: randomized bench comparing the controller against a count-based job model.
// The kernel is modelled as a FIFO of entry timestamps with a fixed latency.
module tb_kernel_b_stream_ctrl;
    localparam int CNTW    = 32;
    localparam int MAXINFL = 8;

    logic            clk = 1'b0;
    logic            rst, start, abort;
    logic [CNTW-1:0] nitems;
    logic            busy, done;
    logic [CNTW-1:0] in_cnt, out_cnt;
    logic            src_valid, src_ready, k_ivalid, k_iready;
    logic            k_ovalid, k_oready, snk_valid, snk_ready;

    kernel_b_stream_ctrl #(.CNTW(CNTW), .MAXINFL(MAXINFL)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .nitems(nitems),
        .busy(busy), .done(done), .in_cnt(in_cnt), .out_cnt(out_cnt),
        .src_valid(src_valid), .src_ready(src_ready), .k_ivalid(k_ivalid), .k_iready(k_iready),
        .k_ovalid(k_ovalid), .k_oready(k_oready), .snk_valid(snk_valid), .snk_ready(snk_ready)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // job model: active flag, pending done pulse, job size and item counts
    bit act = 0;
    bit mdone = 0;
    int mn = 0, m_in = 0, m_out = 0;
    int kt[$];
    int cyc = 0;
    int p_src = 100, p_kin = 100, p_snk = 100, lat = 3, snk_off = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic cycle();
        bit gin, ia, oa, was;
        src_valid = ($urandom_range(99) < p_src);
        k_iready  = ($urandom_range(99) < p_kin);
        snk_ready = (cyc >= snk_off) && ($urandom_range(99) < p_snk);
        k_ovalid  = (kt.size() > 0) && (cyc - kt[0] >= lat);
        @(negedge clk);
        gin = act && (m_in < mn) && (m_in - m_out < MAXINFL);
        check("k_ivalid", k_ivalid, src_valid & gin);
        check("src_ready", src_ready, k_iready & gin);
        check("snk_valid", snk_valid, k_ovalid & act);
        check("k_oready", k_oready, snk_ready & act);
        check("busy", busy, act);
        check("done", done, mdone);
        check("in_cnt", in_cnt, m_in);
        check("out_cnt", out_cnt, m_out);
        ia  = src_valid && k_iready && gin;
        oa  = k_ovalid && snk_ready && act;
        was = mdone;
        if (rst || (act && abort)) begin
            kt.delete();
            act   = 0;
            mdone = 0;
            if (rst) begin
                mn    = 0;
                m_in  = 0;
                m_out = 0;
            end
        end else begin
            if (ia) kt.push_back(cyc);
            if (oa) void'(kt.pop_front());
            mdone = 0;
            m_in  += int'(ia);
            m_out += int'(oa);
            if (act && m_out == mn) begin
                act   = 0;
                mdone = 1;
            end else if (!act && !was && start) begin
                mn    = int'(nitems);
                m_in  = 0;
                m_out = 0;
                if (nitems == 0) mdone = 1;
                else act = 1;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        start = 0;
        abort = 0;
        rst   = 0;
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget && (act || mdone); i++) cycle();
        check("timeout_active", {31'b0, act}, 32'd0);
    endtask

    task automatic launch(input int n);
        nitems = CNTW'(n);
        start  = 1;
        cycle();
    endtask

    initial begin
        rst = 1; start = 0; abort = 0; nitems = '0;
        src_valid = 0; k_iready = 0; k_ovalid = 0; snk_ready = 0;
        @(posedge clk);
        #1;
        rst = 1;
        cycle();
        cycle();

        // four items, kernel latency 3, everything ready
        launch(4);
        wait_idle(100);
        check("basic_in_cnt", in_cnt, 32'd4);
        check("basic_out_cnt", out_cnt, 32'd4);

        // empty job: done pulse without ever going busy
        launch(0);
        wait_idle(10);
        check("empty_in_cnt", in_cnt, 32'd0);

        // sink stalled: in-flight limit caps input accepts
        lat = 1;
        snk_off = cyc + 30;
        launch(20);
        repeat (29) cycle();
        check("maxinfl_in_cnt", in_cnt, 32'd8);
        check("maxinfl_src_ready", src_ready, 32'd0);
        wait_idle(300);
        check("maxinfl_out_cnt", out_cnt, 32'd20);

        // abort after five accepts, then a normal small job
        launch(10);
        for (int i = 0; i < 50 && m_in < 5; i++) cycle();
        abort = 1;
        cycle();
        check("abort_in_cnt", in_cnt, 32'd5);
        check("abort_busy", busy, 32'd0);
        cycle();
        launch(2);
        wait_idle(100);
        check("after_abort_out", out_cnt, 32'd2);

        // random handshakes and kernel latencies
        for (int r = 0; r < 4; r++) begin
            p_src = $urandom_range(100, 30);
            p_kin = $urandom_range(100, 30);
            p_snk = $urandom_range(100, 30);
            lat   = $urandom_range(5, 0);
            launch(100);
            wait_idle(4000);
            check("rand_out_cnt", out_cnt, 32'd100);
            cycle();
        end

        // reset in DRAIN with three in flight; simultaneous start is ignored
        p_src = 100; p_kin = 100; p_snk = 100; lat = 2;
        snk_off = cyc + 1000;
        launch(3);
        repeat (6) cycle();
        check("drain_busy", busy, 32'd1);
        check("drain_in_cnt", in_cnt, 32'd3);
        rst = 1;
        start = 1;
        nitems = CNTW'(5);
        cycle();
        check("rst_busy", busy, 32'd0);
        check("rst_src_ready", src_ready, 32'd0);
        check("rst_snk_valid", snk_valid, 32'd0);
        check("rst_k_oready", k_oready, 32'd0);
        check("rst_in_cnt", in_cnt, 32'd0);
        snk_off = 0;
        repeat (3) cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/kernel_b_stream_ctrl.md
KERNEL_B_STREAM_CTRL -- requirements
Module: kernel_b_stream_ctrl

Interface
REQ-001 Parameter CNTW, default 32: width of item count and status counters.
REQ-002 Parameter MAXINFL, default 8: maximum items in flight inside kernel pipeline (1..255).
REQ-003 One clock; reset is synchronous and active-high.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 start  input  1  single-cycle job start request.
REQ-007 abort  input  1  cancel current job.
REQ-008 nitems  input  CNTW  number of stream items in the job; sampled on accepted start.
REQ-009 busy  output  1  high in RUN and DRAIN.
REQ-010 done  output  1  one-cycle pulse on job completion.
REQ-011 in_cnt  output  CNTW  items accepted into kernel this job.
REQ-012 out_cnt  output  CNTW  items delivered to sink this job.
REQ-013 src_valid  input  1  source stream data valid.
REQ-014 src_ready  output  1  source stream may advance.
REQ-015 k_ivalid  output  1  kernel input valid (to kernel ivalid).
REQ-016 k_iready  input  1  kernel input ready (from kernel iready).
REQ-017 k_ovalid  input  1  kernel output valid (from kernel ovalid).
REQ-018 k_oready  output  1  kernel output ready (to kernel oready).
REQ-019 snk_valid  output  1  sink stream data valid.
REQ-020 snk_ready  input  1  sink accepts data.

Function
REQ-021 FSM states IDLE, RUN, DRAIN, DONE; state register, counters and inflight counter are the only storage.
REQ-022 IDLE: start=1, nitems>0 -> RUN, latch nitems, clear in_cnt/out_cnt/inflight; start=1, nitems=0 -> DONE; start ignored in all other states.
REQ-023 gate_in = (state==RUN) & (in_cnt<latched n) & (inflight<MAXINFL).
REQ-024 k_ivalid = src_valid & gate_in; src_ready = k_iready & gate_in; both combinational, no added latency.
REQ-025 Input accept = k_ivalid & k_iready; increments in_cnt by 1.
REQ-026 gate_out = state in {RUN, DRAIN}; snk_valid = k_ovalid & gate_out; k_oready = snk_ready & gate_out.
REQ-027 Output accept = snk_valid & snk_ready; increments out_cnt by 1.
REQ-028 inflight +1 on input accept only, -1 on output accept only, unchanged when both or neither occur in a cycle.
REQ-029 RUN -> DRAIN on the cycle an input accept makes in_cnt equal latched n.
REQ-030 DRAIN -> DONE on the cycle an output accept makes out_cnt equal latched n; src_ready/k_ivalid held 0 in DRAIN.
REQ-031 DONE: done=1 for exactly one cycle, then IDLE unconditionally; in_cnt/out_cnt hold final values until next accepted start.
REQ-032 abort=1 in RUN or DRAIN -> IDLE next cycle, no done pulse, counters hold; abort has priority over every other transition; ignored in IDLE/DONE.
REQ-033 Kernel outputs appearing with gate_out=0 are stalled (k_oready=0), never dropped.
REQ-034 Counters do not wrap: in_cnt never exceeds latched n, inflight never exceeds MAXINFL.
REQ-035 busy, done, k_ivalid, src_ready, snk_valid, k_oready are never X after reset.

Reset
REQ-036 rst=1 at any clock edge, including mid-job: state -> IDLE, in_cnt=0, out_cnt=0, inflight=0, latched n=0.
REQ-037 During and after reset until start: busy=0, done=0, src_ready=0, k_ivalid=0, k_oready=0, snk_valid=0.
REQ-038 rst overrides start and abort in the same cycle.

Verification
REQ-039 nitems=4, src_valid/k_iready/snk_ready=1, kernel latency 3 -> 4 input accepts on consecutive cycles, DRAIN, done one cycle after 4th output accept, in_cnt=out_cnt=4.
REQ-040 MAXINFL=8, nitems=20, snk_ready=0 for 30 cycles -> exactly 8 input accepts then src_ready=0; release snk_ready -> job completes with out_cnt=20.
REQ-041 nitems=0 start -> busy never 1, done pulse the cycle after start, counters 0.
REQ-042 nitems=10, abort after 5 input accepts -> IDLE next cycle, done never pulses, in_cnt=5; new start nitems=2 completes normally.
REQ-043 Random src_valid/k_iready/snk_ready toggling, nitems=100 -> inflight within 0..MAXINFL every cycle, out_cnt=100 at done, no item lost or duplicated.
REQ-044 rst asserted in DRAIN with inflight=3 -> all outputs return to REQ-037 values next cycle; start with start=1 and rst=1 same cycle is ignored.
